// File: rtl/prog_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_updown_counter: up/down counter with clock-enable prescaler, load,    |
// | programmable modulus and wrap/saturate mode.            Revision: 1.0      |
// +----------------------------------------------------------------------------+
module prog_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 15,
  parameter int DIV       = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic             slow_sq
);

  localparam int             PW       = $clog2(DIV + 1);
  localparam logic [PW-1:0]  PSC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0]  PSC_ONE  = PW'(1);
  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

  logic [PW-1:0]    r_psc;
  logic             w_psc_wrap;
  logic             w_at_bound;
  logic             w_slow_next;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_next_count;

  always_comb begin
    w_psc_wrap     = (r_psc == PSC_LAST);
    w_load_clamped = (load_val > MAX_C) ? MAX_C : load_val;
    w_at_bound     = up_dn ? (count == MAX_C) : (count == '0);
    w_next_count   = count;
    if (w_at_bound) begin
      if (!sat) w_next_count = up_dn ? '0 : MAX_C;
    end else begin
      w_next_count = up_dn ? (count + ONE_C) : (count - ONE_C);
    end
  end

  // A single-cycle period has no low phase, so the square wave is held high.
  generate
    if (DIV == 1) begin : g_slow_div1
      assign w_slow_next = 1'b1;
    end else begin : g_slow_divn
      localparam logic [PW-1:0] PSC_HALF = PW'(DIV / 2);
      assign w_slow_next = (r_psc < PSC_HALF);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      r_psc   <= '0;
      tick    <= 1'b0;
      tc      <= 1'b0;
      slow_sq <= 1'b1;
    end else begin
      slow_sq <= w_slow_next;
      if (load) begin
        // A tick pending in this cycle is dropped and the period restarts.
        count <= w_load_clamped;
        r_psc <= '0;
        tick  <= 1'b0;
        tc    <= 1'b0;
      end else begin
        if (en) r_psc <= w_psc_wrap ? '0 : (r_psc + PSC_ONE);
        tick <= en && w_psc_wrap;
        tc   <= tick && w_at_bound;
        if (tick) count <= w_next_count;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_updown_counter.sv
`default_nettype none
// Testbench for prog_updown_counter: scoreboard of expected outputs plus
// per-scenario directed checks on a DIV=4 instance and a DIV=1 instance.
module tb_prog_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=4, MAX_COUNT=9, DIV=4
  logic       rst, en, up_dn, sat, load;
  logic [3:0] load_val, count;
  logic       tick, tc, slow_sq;

  // Instance B: WIDTH=8, MAX_COUNT=255, DIV=1
  logic       rst_b, en_b, up_dn_b, sat_b, load_b;
  logic [7:0] load_val_b, count_b;
  logic       tick_b, tc_b, slow_sq_b;

  prog_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .DIV(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
    .load_val(load_val), .count(count), .tick(tick), .tc(tc), .slow_sq(slow_sq)
  );

  prog_updown_counter #(.WIDTH(8), .MAX_COUNT(255), .DIV(1)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .up_dn(up_dn_b), .sat(sat_b), .load(load_b),
    .load_val(load_val_b), .count(count_b), .tick(tick_b), .tc(tc_b), .slow_sq(slow_sq_b)
  );

  typedef struct packed {
    logic [3:0] count;
    logic       tick;
    logic       tc;
    logic       sq;
  } exp_a_t;

  typedef struct packed {
    logic [7:0] count;
    logic       tick;
    logic       tc;
    logic       sq;
  } exp_b_t;

  exp_a_t sb_a[$];
  exp_b_t sb_b[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference state for instance A
  int m_count, m_psc;
  logic m_tick, m_tc, m_sq;
  // Reference state for instance B
  int mb_count;
  logic mb_tick, mb_tc;

  // Scoreboard consumers: one expected entry per clock edge driven.
  always @(posedge clk) begin
    exp_a_t ea;
    exp_b_t eb;
    #1;
    if (sb_a.size() > 0) begin
      ea = sb_a.pop_front();
      n_cmp++;
      if ({count, tick, tc, slow_sq} !== {ea.count, ea.tick, ea.tc, ea.sq}) begin
        n_err++;
        $display("FAIL sb_a @%0t: got count=%0d tick=%b tc=%b sq=%b, want count=%0d tick=%b tc=%b sq=%b",
                 $time, count, tick, tc, slow_sq, ea.count, ea.tick, ea.tc, ea.sq);
      end
    end
    if (sb_b.size() > 0) begin
      eb = sb_b.pop_front();
      n_cmp++;
      if ({count_b, tick_b, tc_b, slow_sq_b} !== {eb.count, eb.tick, eb.tc, eb.sq}) begin
        n_err++;
        $display("FAIL sb_b @%0t: got count=%0d tick=%b tc=%b sq=%b, want count=%0d tick=%b tc=%b sq=%b",
                 $time, count_b, tick_b, tc_b, slow_sq_b, eb.count, eb.tick, eb.tc, eb.sq);
      end
    end
  end

  // Drive one cycle on instance A, push the expected post-edge outputs, and
  // return at the following falling edge.
  task automatic drive_a(input logic r, input logic e, input logic u, input logic s,
                         input logic l, input logic [3:0] lv);
    exp_a_t x;
    logic   step;
    logic   nsq;
    rst = r; en = e; up_dn = u; sat = s; load = l; load_val = lv;
    if (r) begin
      m_count = 0; m_psc = 0; m_tick = 1'b0; m_tc = 1'b0; m_sq = 1'b1;
    end else begin
      nsq = (m_psc < 2);
      if (l) begin
        m_count = (lv > 4'd9) ? 9 : int'(lv);
        m_psc = 0; m_tick = 1'b0; m_tc = 1'b0;
      end else begin
        step   = m_tick;
        m_tick = e && (m_psc == 3);
        if (e) m_psc = (m_psc == 3) ? 0 : m_psc + 1;
        m_tc = 1'b0;
        if (step) begin
          if (u) begin
            if (m_count == 9) begin m_tc = 1'b1; if (!s) m_count = 0; end
            else m_count = m_count + 1;
          end else begin
            if (m_count == 0) begin m_tc = 1'b1; if (!s) m_count = 9; end
            else m_count = m_count - 1;
          end
        end
      end
      m_sq = nsq;
    end
    x.count = 4'(m_count); x.tick = m_tick; x.tc = m_tc; x.sq = m_sq;
    sb_a.push_back(x);
    @(negedge clk);
  endtask

  task automatic drive_b(input logic r, input logic e);
    exp_b_t x;
    logic   step;
    rst_b = r; en_b = e;
    if (r) begin
      mb_count = 0; mb_tick = 1'b0; mb_tc = 1'b0;
    end else begin
      step    = mb_tick;
      mb_tick = e;
      mb_tc   = 1'b0;
      if (step) begin
        if (mb_count == 255) begin mb_tc = 1'b1; mb_count = 0; end
        else mb_count = mb_count + 1;
      end
    end
    x.count = 8'(mb_count); x.tick = mb_tick; x.tc = mb_tc; x.sq = 1'b1;
    sb_b.push_back(x);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive_a(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
    n_cmp++;
    if ({count, tick, tc, slow_sq} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset: got count=%0d tick=%b tc=%b sq=%b, want 0 0 0 1", count, tick, tc, slow_sq);
    end
  endtask

  task automatic test_count_up();
    int nt = 0;
    int ntc = 0;
    for (int i = 0; i < 44; i++) begin
      drive_a(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      if (tick === 1'b1) nt++;
      if (tc === 1'b1) ntc++;
    end
    n_cmp++;
    if (nt != 11) begin n_err++; $display("FAIL up_ticks: got %0d, want 11", nt); end
    n_cmp++;
    if (ntc != 1) begin n_err++; $display("FAIL up_tc_pulses: got %0d, want 1", ntc); end
    n_cmp++;
    if (count !== 4'd0) begin n_err++; $display("FAIL up_final_count: got %0d, want 0", count); end
  endtask

  task automatic test_down_wrap();
    drive_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    n_cmp++;
    if ({count, tc} !== {4'd9, 1'b1}) begin
      n_err++; $display("FAIL down_wrap: got count=%0d tc=%b, want 9 1", count, tc);
    end
    for (int i = 0; i < 4; i++) drive_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    n_cmp++;
    if ({count, tc} !== {4'd8, 1'b0}) begin
      n_err++; $display("FAIL down_next: got count=%0d tc=%b, want 8 0", count, tc);
    end
  endtask

  task automatic test_sat_hold();
    int ntc = 0;
    drive_a(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd9);
    for (int i = 0; i < 13; i++) begin
      drive_a(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      if (tc === 1'b1) ntc++;
      n_cmp++;
      if (count !== 4'd9) begin n_err++; $display("FAIL sat_hold: got count=%0d, want 9", count); end
    end
    n_cmp++;
    if (ntc != 3) begin n_err++; $display("FAIL sat_tc_pulses: got %0d, want 3", ntc); end
  endtask

  task automatic test_load_tick();
    for (int i = 0; i < 3; i++) drive_a(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    n_cmp++;
    if (tick !== 1'b1) begin n_err++; $display("FAIL load_pretick: got tick=%b, want 1", tick); end
    drive_a(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd12);
    n_cmp++;
    if ({count, tc, tick} !== {4'd9, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL load_clamp: got count=%0d tc=%b tick=%b, want 9 0 0", count, tc, tick);
    end
    for (int i = 1; i <= 4; i++) begin
      drive_a(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      n_cmp++;
      if (tick !== (i == 4)) begin
        n_err++; $display("FAIL load_next_tick cycle %0d: got tick=%b, want %b", i, tick, (i == 4));
      end
    end
  endtask

  task automatic test_en_freeze();
    for (int i = 0; i < 2; i++) drive_a(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      drive_a(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      n_cmp++;
      if ({count, tick} !== {4'd0, 1'b0}) begin
        n_err++; $display("FAIL freeze: got count=%0d tick=%b, want 0 0", count, tick);
      end
    end
    for (int i = 1; i <= 2; i++) begin
      drive_a(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      n_cmp++;
      if (tick !== (i == 2)) begin
        n_err++; $display("FAIL resume cycle %0d: got tick=%b, want %b", i, tick, (i == 2));
      end
    end
  endtask

  task automatic test_div1();
    int ntc = 0;
    drive_b(1'b1, 1'b0);
    for (int k = 1; k <= 258; k++) begin
      drive_b(1'b0, 1'b1);
      if (tc_b === 1'b1) ntc++;
      n_cmp++;
      if (count_b !== 8'((k - 1) % 256)) begin
        n_err++; $display("FAIL div1_count k=%0d: got %0d, want %0d", k, count_b, (k - 1) % 256);
      end
    end
    n_cmp++;
    if (ntc != 1) begin n_err++; $display("FAIL div1_tc_pulses: got %0d, want 1", ntc); end
    drive_b(1'b1, 1'b1);
    n_cmp++;
    if ({count_b, tick_b, tc_b, slow_sq_b} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL div1_reset: got count=%0d tick=%b tc=%b sq=%b, want 0 0 0 1",
               count_b, tick_b, tc_b, slow_sq_b);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; sat = 1'b0; load = 1'b0; load_val = '0;
    rst_b = 1'b1; en_b = 1'b0; up_dn_b = 1'b1; sat_b = 1'b0; load_b = 1'b0; load_val_b = '0;
    @(negedge clk);
    test_reset();
    test_count_up();
    test_down_wrap();
    test_sat_hold();
    test_load_tick();
    test_en_freeze();
    test_div1();
    @(negedge clk);
    n_cmp++;
    if (sb_a.size() + sb_b.size() != 0) begin
      n_err++; $display("FAIL sb_drain: got %0d left, want 0", sb_a.size() + sb_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
